// File: rtl/clock_display_driver_if.sv
// Time-value handshake between the time-of-day counter and the display driver.
//   time_valid : source -> sink, time_bcd holds a new value
//   time_bcd   : source -> sink, {h_tens, h_ones, m_tens, m_ones} packed BCD
//   time_ready : sink -> source, one-entry pending buffer is empty
// master = time source, slave = display driver.
interface clock_display_driver_if;
  logic        time_valid;
  logic [15:0] time_bcd;
  logic        time_ready;

  modport master (
    output time_valid,
    output time_bcd,
    input  time_ready
  );

  modport slave (
    input  time_valid,
    input  time_bcd,
    output time_ready
  );
endinterface

// File: rtl/clock_display_driver.sv
// Display-side consumer of the time-of-day counter. Buffers one packed BCD
// HH:MM value and commits it to the display only at frame boundaries, then
// scans a 4-digit multiplexed, active-low 7-segment display with a per-slot
// anti-ghosting blank window, colon on digit 2, leading-zero blanking of the
// hours-tens digit and a sticky invalid-digit flag.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : time handshake (slave side: time_valid, time_bcd, time_ready)
//   dp_in      : colon request, shown on digit 2
//   seg_n      : segments {g,f,e,d,c,b,a}, active-low
//   dp_n       : decimal point, active-low
//   an_n       : digit enables, active-low, bit0 = m_ones .. bit3 = h_tens
//   bcd_err    : sticky, an invalid BCD digit was displayed
module clock_display_driver #(
  parameter int unsigned SCAN_DIV   = 12500,
  parameter int unsigned BLANK_TIME = 250
) (
  input  logic                        clk,
  input  logic                        rst_n,
  clock_display_driver_if.slave       bus,
  input  logic                        dp_in,
  output logic [6:0]                  seg_n,
  output logic                        dp_n,
  output logic [3:0]                  an_n,
  output logic                        bcd_err
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] disp, disp_nxt;
  logic [15:0] pend;
  logic        last, boundary, accept;
  logic [3:0]  digit_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Outputs are registered from the next-state values so that they line up
  // with the slot counter of the same cycle (first ON at counter == BLANK_TIME).
  always_comb begin
    last     = (cnt == 16'(SCAN_DIV - 1));
    cnt_nxt  = last ? '0 : cnt + 16'd1;
    idx_nxt  = last ? idx + 2'd1 : idx;
    boundary = last && (idx == 2'd3);
    // time_ready is the inverted pending-full flag
    accept   = bus.time_valid && bus.time_ready;
    disp_nxt = (boundary && !bus.time_ready) ? pend : disp;

    state_nxt = state;
    case (state)
      ST_BLANK: if (cnt_nxt >= 16'(BLANK_TIME)) state_nxt = ST_ON;
      ST_ON:    if (last && (BLANK_TIME != 0)) state_nxt = ST_BLANK;
      default:  state_nxt = ST_BLANK;
    endcase

    digit_nxt = disp_nxt[{idx_nxt, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_BLANK;
      cnt            <= '0;
      idx            <= '0;
      disp           <= '0;
      pend           <= '0;
      bus.time_ready <= 1'b1;
      seg_n          <= '1;
      dp_n           <= 1'b1;
      an_n           <= '1;
      bcd_err        <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      disp  <= disp_nxt;

      if (accept) begin
        pend           <= bus.time_bcd;
        bus.time_ready <= 1'b0;
      end else if (boundary) begin
        bus.time_ready <= 1'b1;
      end

      if (state_nxt == ST_ON) begin
        an_n <= ~(4'b0001 << idx_nxt);
        if (idx_nxt == 2'd3 && digit_nxt == 4'd0)
          seg_n <= '1;
        else
          seg_n <= seg7(digit_nxt);
        dp_n <= ~(dp_in && idx_nxt == 2'd2);
        if (digit_nxt > 4'd9)
          bcd_err <= 1'b1;
      end else begin
        an_n  <= '1;
        seg_n <= '1;
        dp_n  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_display_driver.sv
module tb_clock_display_driver;
  localparam int unsigned SD    = 16;
  localparam int unsigned BT    = 4;
  localparam int unsigned FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dp_in = 1'b0;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;
  logic       bcd_err;

  clock_display_driver_if bus ();

  clock_display_driver #(.SCAN_DIV(SD), .BLANK_TIME(BT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .dp_in   (dp_in),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .an_n    (an_n),
    .bcd_err (bcd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       rdy;
    logic       err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] pend_q[$];
  int unsigned tcount = 0;
  logic [15:0] shown = '0;
  logic        m_err = 1'b0;
  int unsigned acc_count = 0;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Reference model: absolute time since reset gives slot position and digit
  // index; a queue holds the one pending value; the shown word changes only
  // at the end of each 4-slot frame.
  always @(posedge clk) begin : model
    exp_t        e;
    int unsigned slot, di;
    logic [3:0]  dig;
    logic        rdy_pre;
    if (!rst_n) begin
      tcount = 0;
      shown  = '0;
      m_err  = 1'b0;
      pend_q.delete();
    end else begin
      rdy_pre = (pend_q.size() == 0);
      if ((tcount % FRAME) == FRAME - 1 && pend_q.size() != 0)
        shown = pend_q.pop_front();
      if (bus.time_valid && rdy_pre) begin
        pend_q.push_back(bus.time_bcd);
        acc_count++;
      end
      tcount++;
    end
    slot = tcount % SD;
    di   = (tcount / SD) % 4;
    dig  = shown[di*4 +: 4];
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    if (slot >= BT) begin
      e.an  = ~(4'b0001 << di);
      e.seg = (di == 3 && dig == 4'd0) ? 7'h7F : seg_of(dig);
      e.dp  = !(dp_in && di == 2);
      if (dig > 4'd9) m_err = 1'b1;
    end
    e.rdy = (pend_q.size() == 0);
    e.err = m_err;
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("an_n",       16'(an_n),           16'(e.an));
      chk("seg_n",      16'(seg_n),          16'(e.seg));
      chk("dp_n",       16'(dp_n),           16'(e.dp));
      chk("time_ready", 16'(bus.time_ready), 16'(e.rdy));
      chk("bcd_err",    16'(bcd_err),        16'(e.err));
    end
  end

  task automatic send(input logic [15:0] word);
    int unsigned n0;
    bit          got;
    @(negedge clk);
    bus.time_valid = 1'b1;
    bus.time_bcd   = word;
    n0  = acc_count;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (acc_count != n0) begin
        got = 1'b1;
        break;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL accept_timeout word=%h: actual=not accepted required=accepted", word);
    end
    bus.time_valid = 1'b0;
  endtask

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    bit hit;
    bus.time_valid = 1'b0;
    bus.time_bcd   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);

    send(16'h1234);  repeat (140) @(negedge clk);
    send(16'h0905);  repeat (140) @(negedge clk);
    send(16'h1111);  send(16'h2222);  repeat (200) @(negedge clk);
    send(16'h1A00);  repeat (140) @(negedge clk);
    send(16'h1200);  repeat (140) @(negedge clk);

    dp_in = 1'b1;  repeat (130) @(negedge clk);
    dp_in = 1'b0;  repeat (70) @(negedge clk);

    // reset during digit-1 ON with a value pending
    send(16'h4321);
    send(16'h5678);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((tcount % FRAME) == SD + BT + 2 && pend_q.size() != 0) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL midframe_setup: actual=not reached required=idx1 ON with pending");
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);

    for (int n = 0; n < 30; n++) begin
      dp_in = 1'($urandom_range(0, 1));
      send({rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit()});
      repeat ($urandom_range(0, 100)) @(negedge clk);
    end
    repeat (140) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
